// File: rtl/commit_trace_buf.sv
// ============================================================================
// Module   : commit_trace_buf
// Brief    : Captures committed-instruction records into a FIFO and streams
//            each one as 3-6 (4-7 with COMMIT_TRACE_TS_EN) 32-bit trace words,
//            throttling the CPU through global_en.
// Revision : 1.0
// ============================================================================
`default_nettype none

module commit_trace_buf #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     commit,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic                     commit_halt,
    input  logic                     commit_reg_we,
    input  logic [4:0]               commit_reg_wa,
    input  logic [31:0]              commit_reg_wd,
    input  logic                     commit_dmem_we,
    input  logic [31:0]              commit_dmem_wa,
    input  logic [31:0]              commit_dmem_wd,
    output logic                     global_en,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_data,
    output logic                     trace_last,
    output logic                     halted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef COMMIT_TRACE_TS_EN
    localparam logic TS_BIT = 1'b1;
`else
    localparam logic TS_BIT = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  seq;
        logic        halt;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
        logic [31:0] pc;
        logic [31:0] inst;
`ifdef COMMIT_TRACE_TS_EN
        logic [31:0] ts;
`endif
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_TS   = 3'd2,
        S_PC   = 3'd3,
        S_INST = 3'd4,
        S_RWD  = 3'd5,
        S_DWA  = 3'd6,
        S_DWD  = 3'd7
    } state_e;

    // Word that follows state s for record r; S_IDLE means s was the final word.
    function automatic state_e next_word(input state_e s, input rec_t r);
        state_e n;
        n = S_IDLE;
        case (s)
`ifdef COMMIT_TRACE_TS_EN
            S_HDR:  n = S_TS;
            S_TS:   n = S_PC;
`else
            S_HDR:  n = S_PC;
`endif
            S_PC:   n = S_INST;
            S_INST: n = r.reg_we ? S_RWD : (r.dmem_we ? S_DWA : S_IDLE);
            S_RWD:  n = r.dmem_we ? S_DWA : S_IDLE;
            S_DWA:  n = S_DWD;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] word_of(input state_e s, input rec_t r);
        logic [31:0] w;
        w = 32'h0;
        case (s)
            S_HDR:  w = {8'hC0, r.seq, 7'b0, r.halt, r.dmem_we, r.reg_we, TS_BIT, r.reg_wa};
`ifdef COMMIT_TRACE_TS_EN
            S_TS:   w = r.ts;
`endif
            S_PC:   w = r.pc;
            S_INST: w = r.inst;
            S_RWD:  w = r.reg_wd;
            S_DWA:  w = r.dmem_wa;
            S_DWD:  w = r.dmem_wd;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic last_of(input state_e s, input rec_t r);
        return (s != S_IDLE) && (next_word(s, r) == S_IDLE);
    endfunction

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    seq_q;
    logic          halted_q, overflow_q, en_q;
`ifdef COMMIT_TRACE_TS_EN
    logic [31:0]   ts_q;
`endif

    state_e        state_q;
    rec_t          hold_q;
    logic          trace_valid_q, trace_last_q;
    logic [31:0]   trace_data_q;

    rec_t          rec_in;
    rec_t          head;
    state_e        nxt;
    logic          w_hs, w_empty, w_full, w_push, w_push_ok, w_pop;

    assign global_en   = run & ~halted_q & (count_q <= CW'(DEPTH - AFULL_MARGIN));
    assign trace_valid = trace_valid_q;
    assign trace_data  = trace_data_q;
    assign trace_last  = trace_last_q;
    assign halted      = halted_q;
    assign overflow    = overflow_q;
    assign count       = count_q;

    // commit is sticky on the CPU side; only a cycle after an enabled step is it new.
    assign w_push    = commit & en_q;
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CW'(DEPTH));
    assign w_push_ok = w_push & ~w_full;
    assign w_hs      = trace_valid_q & trace_ready;
    assign w_pop     = ~w_empty & ((state_q == S_IDLE) | (w_hs & trace_last_q));
    assign head      = mem[rd_ptr_q];
    assign nxt       = next_word(state_q, hold_q);

    always_comb begin
        rec_in         = '0;
        rec_in.seq     = seq_q;
        rec_in.halt    = commit_halt;
        rec_in.reg_we  = commit_reg_we;
        rec_in.reg_wa  = commit_reg_wa;
        rec_in.reg_wd  = commit_reg_wd;
        rec_in.dmem_we = commit_dmem_we;
        rec_in.dmem_wa = commit_dmem_wa;
        rec_in.dmem_wd = commit_dmem_wd;
        rec_in.pc      = commit_pc;
        rec_in.inst    = commit_inst;
`ifdef COMMIT_TRACE_TS_EN
        rec_in.ts      = ts_q;
`endif
    end

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem[wr_ptr_q] <= rec_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
            en_q       <= 1'b0;
`ifdef COMMIT_TRACE_TS_EN
            ts_q       <= '0;
`endif
        end else begin
            en_q    <= global_en;
            count_q <= count_d;
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push) begin
                seq_q <= seq_q + 8'd1;
                if (w_full) begin
                    overflow_q <= 1'b1;
                end
                if (commit_halt) begin
                    halted_q <= 1'b1;
                end
            end
`ifdef COMMIT_TRACE_TS_EN
            if (global_en) begin
                ts_q <= ts_q + 32'd1;
            end
`endif
        end
    end

    // Serialiser: a record is popped into hold_q as its HDR word is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            trace_valid_q <= 1'b0;
            trace_data_q  <= 32'h0;
            trace_last_q  <= 1'b0;
        end else if (w_pop) begin
            state_q       <= S_HDR;
            hold_q        <= head;
            trace_valid_q <= 1'b1;
            trace_data_q  <= word_of(S_HDR, head);
            trace_last_q  <= 1'b0;
        end else if (w_hs) begin
            state_q       <= nxt;
            trace_valid_q <= (nxt != S_IDLE);
            trace_data_q  <= word_of(nxt, hold_q);
            trace_last_q  <= last_of(nxt, hold_q);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
// ============================================================================
// Module   : tb_commit_trace_buf
// Brief    : Self-checking bench for commit_trace_buf: queue-based record/word
//            model compared every cycle plus literal expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_commit_trace_buf;

    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic        clk, rst, run, commit;
    logic [31:0] commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd;
    logic        commit_halt, commit_reg_we, commit_dmem_we;
    logic [4:0]  commit_reg_wa;
    logic        global_en, trace_valid, trace_ready, trace_last, halted, overflow;
    logic [31:0] trace_data;
    logic [4:0]  count;

    commit_trace_buf #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
        .clk(clk), .rst(rst), .run(run), .commit(commit),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_halt(commit_halt),
        .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
        .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
        .global_en(global_en), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_last(trace_last), .halted(halted),
        .overflow(overflow), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] w; logic last; } word_t;
    word_t       exp_q[$];
    int          rec_len_q[$];
    int          m_left   = 0;
    logic [7:0]  m_seq    = 8'd0;
    bit          m_halted = 0;
    bit          m_over   = 0;
    bit          m_enq    = 0;
    logic [31:0] m_ts     = 32'd0;

    function automatic bit m_gen();
        return run && !m_halted && (rec_len_q.size() <= DEPTH - AFM);
    endfunction

    task automatic add_word(input logic [31:0] w, input logic last, inout int len);
        word_t e;
        e.w = w; e.last = last;
        exp_q.push_back(e);
        len++;
    endtask

    task automatic add_record();
        int len;
        bit tsb;
        len = 0;
`ifdef COMMIT_TRACE_TS_EN
        tsb = 1'b1;
`else
        tsb = 1'b0;
`endif
        add_word({8'hC0, m_seq, 7'b0, commit_halt, commit_dmem_we, commit_reg_we, tsb, commit_reg_wa}, 1'b0, len);
        if (tsb) add_word(m_ts, 1'b0, len);
        add_word(commit_pc, 1'b0, len);
        add_word(commit_inst, !commit_reg_we && !commit_dmem_we, len);
        if (commit_reg_we) add_word(commit_reg_wd, !commit_dmem_we, len);
        if (commit_dmem_we) begin
            add_word(commit_dmem_wa, 1'b0, len);
            add_word(commit_dmem_wd, 1'b1, len);
        end
        rec_len_q.push_back(len);
    endtask

    always @(posedge clk or negedge rst) begin
        bit hs, free, pop, full, gen;
        if (!rst) begin
            exp_q.delete(); rec_len_q.delete();
            m_left = 0; m_seq = 8'd0; m_halted = 0; m_over = 0; m_enq = 0; m_ts = 32'd0;
        end else begin
            gen  = m_gen();
            hs   = (m_left > 0) && trace_ready;
            free = (m_left == 0) || (hs && m_left == 1);
            full = (rec_len_q.size() == DEPTH);
            pop  = free && (rec_len_q.size() > 0);
            if (hs) begin
                m_left--;
                void'(exp_q.pop_front());
            end
            if (pop) m_left = rec_len_q.pop_front();
            if (commit && m_enq) begin
                if (full) m_over = 1;
                else add_record();
                if (commit_halt) m_halted = 1;
                m_seq++;
            end
            m_enq = gen;
            if (gen) m_ts++;
        end
    end

    // ---------------- per-cycle compare + accepted-word log ----------------
    logic [31:0] log_d[$];
    logic        log_l[$];

    always @(negedge clk) begin
        chk("global_en", {31'b0, global_en}, {31'b0, m_gen()});
        chk("count", {27'b0, count}, 32'(rec_len_q.size()));
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("overflow", {31'b0, overflow}, {31'b0, m_over});
        chk("trace_valid", {31'b0, trace_valid}, {31'b0, m_left > 0});
        if (m_left > 0 && exp_q.size() > 0) begin
            chk("trace_data", trace_data, exp_q[0].w);
            chk("trace_last", {31'b0, trace_last}, {31'b0, exp_q[0].last});
        end
        if (trace_valid && trace_ready) begin
            log_d.push_back(trace_data);
            log_l.push_back(trace_last);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(); @(posedge clk); #2; endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst, input logic halt,
                             input logic rwe, input logic [4:0] rwa, input logic [31:0] rwd,
                             input logic dwe, input logic [31:0] dwa, input logic [31:0] dwd);
        commit = 1'b1; commit_pc = pc; commit_inst = inst; commit_halt = halt;
        commit_reg_we = rwe; commit_reg_wa = rwa; commit_reg_wd = rwd;
        commit_dmem_we = dwe; commit_dmem_wa = dwa; commit_dmem_wd = dwd;
        step();
        commit = 1'b0; commit_halt = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int i;
        i = 0;
        @(negedge clk);
        while (!trace_valid && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        chk("wait_valid_timeout", {31'b0, trace_valid}, 32'd1);
    endtask

    task automatic clear_log(); log_d.delete(); log_l.delete(); endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] w, input logic last);
        if (idx < log_d.size()) begin
            chk(name, log_d[idx], w);
            chk({name, "_last"}, {31'b0, log_l[idx]}, {31'b0, last});
        end else begin
            chk({name, "_missing"}, 32'(log_d.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stall_w;
        bit prev_ge, fell;
        int hidx;
        rst = 1'b0; run = 1'b0; commit = 1'b0; trace_ready = 1'b0;
        commit_pc = '0; commit_inst = '0; commit_halt = 1'b0; commit_reg_we = 1'b0;
        commit_reg_wa = '0; commit_reg_wd = '0; commit_dmem_we = 1'b0;
        commit_dmem_wa = '0; commit_dmem_wd = '0;

        // Reset state with run=0
        repeat (3) step();
        @(negedge clk);
        chk("rst_global_en", {31'b0, global_en}, 32'd0);
        chk("rst_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        step(); rst = 1'b1; run = 1'b1; trace_ready = 1'b1;
        repeat (2) step();

        // Plain record, then full record with both writes
        clear_log();
        do_commit(32'h0000_3000, 32'h0000_0013, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
        repeat (10) step();
        do_commit(32'h0000_3004, 32'h0000_0023, 0, 1, 5'd5, 32'h1234, 1, 32'h100, 32'hAB);
        repeat (12) step();
`ifndef COMMIT_TRACE_TS_EN
        chk("log_size_two_records", 32'(log_d.size()), 32'd9);
        chk_log("r0_hdr",  0, 32'hC000_0000, 1'b0);
        chk_log("r0_pc",   1, 32'h0000_3000, 1'b0);
        chk_log("r0_inst", 2, 32'h0000_0013, 1'b1);
        chk_log("r1_hdr",  3, 32'hC001_00C5, 1'b0);
        chk_log("r1_pc",   4, 32'h0000_3004, 1'b0);
        chk_log("r1_inst", 5, 32'h0000_0023, 1'b0);
        chk_log("r1_rwd",  6, 32'h0000_1234, 1'b0);
        chk_log("r1_dwa",  7, 32'h0000_0100, 1'b0);
        chk_log("r1_dwd",  8, 32'h0000_00AB, 1'b1);
`endif

        // Backpressure mid-record
        do_commit(32'h0000_4000, 32'h0000_0033, 0, 1, 5'd3, 32'h55, 0, 32'h0, 32'h0);
        wait_valid(20);
        @(posedge clk); #2; trace_ready = 1'b0;
        @(negedge clk); stall_w = trace_data;
`ifndef COMMIT_TRACE_TS_EN
        chk("stall_word_is_pc", stall_w, 32'h0000_4000);
`endif
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", trace_data, stall_w);
        end
        step(); trace_ready = 1'b1;
        repeat (10) step();

        // Fill with ready low and commit held high
        trace_ready = 1'b0; commit = 1'b1;
        commit_pc = 32'h0000_7000; commit_inst = 32'h0000_0013;
        commit_reg_we = 1'b0; commit_dmem_we = 1'b0;
        prev_ge = 1'b1; fell = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (prev_ge && !global_en) begin
                chk("ge_fall_count", {27'b0, count}, 32'd15);
                fell = 1'b1;
            end
            prev_ge = global_en;
        end
        chk("ge_fell", {31'b0, fell}, 32'd1);
        chk("fill_count", {27'b0, count}, 32'd16);
        chk("fill_global_en", {31'b0, global_en}, 32'd0);
        chk("fill_overflow", {31'b0, overflow}, 32'd0);
        step(); commit = 1'b0; trace_ready = 1'b1;
        repeat (70) step();
        @(negedge clk);
        chk("drain_count", {27'b0, count}, 32'd0);

        // Halt record drains fully
        step(); trace_ready = 1'b0; clear_log();
        do_commit(32'h0000_5000, 32'h0000_0013, 0, 0, 5'd0, 0, 0, 0, 0);
        do_commit(32'h0000_5004, 32'h0000_0013, 0, 1, 5'd7, 32'h77, 0, 0, 0);
        do_commit(32'h0000_5008, 32'h0010_0073, 1, 0, 5'd0, 0, 0, 0, 0);
        @(negedge clk);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_global_en", {31'b0, global_en}, 32'd0);
        step(); trace_ready = 1'b1;
        repeat (25) step();
        @(negedge clk);
        chk("halt_drain_count", {27'b0, count}, 32'd0);
        chk("halt_drain_valid", {31'b0, trace_valid}, 32'd0);
`ifndef COMMIT_TRACE_TS_EN
        hidx = -1;
        for (int i = 1; i < log_d.size(); i++) if (log_d[i] == 32'h0000_5008) hidx = i;
        if (hidx > 0) chk("halt_hdr_bit8", {31'b0, log_d[hidx-1][8]}, 32'd1);
        else chk("halt_hdr_found", 32'(hidx), 32'd1);
`endif

        // Reset mid-drain, then clean restart
        step(); rst = 1'b0;
        step(); rst = 1'b1; trace_ready = 1'b0;
        repeat (2) step();
        do_commit(32'h0000_8000, 32'h0000_0013, 0, 0, 5'd0, 0, 0, 0, 0);
        do_commit(32'h0000_8004, 32'h0000_0013, 0, 0, 5'd0, 0, 1, 32'h10, 32'h20);
        do_commit(32'h0000_8008, 32'h0010_0073, 1, 0, 5'd0, 0, 0, 0, 0);
        trace_ready = 1'b1;
        repeat (3) step();
        chk("pre_rst_valid", {31'b0, trace_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, trace_valid}, 32'd0);
        chk("mid_rst_count", {27'b0, count}, 32'd0);
        chk("mid_rst_halted", {31'b0, halted}, 32'd0);
        chk("mid_rst_data", trace_data, 32'd0);
        chk("mid_rst_last", {31'b0, trace_last}, 32'd0);
        repeat (2) step();
        rst = 1'b1; clear_log();
        repeat (2) step();
        do_commit(32'h0000_6000, 32'h0000_0013, 0, 0, 5'd0, 0, 0, 0, 0);
        repeat (10) step();
`ifndef COMMIT_TRACE_TS_EN
        chk("restart_log_size", 32'(log_d.size()), 32'd3);
        chk_log("restart_hdr", 0, 32'hC000_0000, 1'b0);
        chk_log("restart_pc",  1, 32'h0000_6000, 1'b0);
        chk_log("restart_inst", 2, 32'h0000_0013, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Sits directly downstream of the CPU's registered commit/debug interface.
- Captures one record per committed instruction into a FIFO and serialises each record into 32-bit words on a valid/ready trace stream for the debug host.
- Drives the CPU's global_en input so the CPU is throttled before the FIFO overflows and stops after a committed halt.

Parameters:
DEPTH, 16, FIFO entries in records; power of two, minimum 4.
AFULL_MARGIN, 2, free entries reserved when global_en drops; minimum 2, covering the one-cycle commit latency.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
run  input  1  level run request from the host
commit  input  1  CPU commit flag; sticky, so it is qualified internally
commit_pc  input  32  committed PC
commit_inst  input  32  committed instruction
commit_halt  input  1  committed instruction is halt
commit_reg_we  input  1  register write enable
commit_reg_wa  input  5  register write address
commit_reg_wd  input  32  register write data
commit_dmem_we  input  1  data memory write enable
commit_dmem_wa  input  32  data memory write address
commit_dmem_wd  input  32  data memory write data
global_en  output  1  CPU step enable
trace_valid  output  1  trace word valid
trace_ready  input  1  host accepts word
trace_data  output  32  trace word
trace_last  output  1  final word of the current record
halted  output  1  sticky: a halt record was captured
overflow  output  1  sticky: a record was dropped because the FIFO was full
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, en_q=0, seq=0, halted=0, overflow=0, trace_valid=0, trace_last=0, trace_data=0, FSM=IDLE.
- global_en = run & ~halted & (count <= DEPTH-AFULL_MARGIN). Combinational.
- en_q <= global_en every cycle.
- Push: when commit & en_q, store the full record plus seq; seq increments by 1 and wraps at 8 bits.
  - Push when full: record dropped, overflow<=1, seq still increments.
- halted <= 1 on a push with commit_halt=1. Cleared only by reset.
- Simultaneous push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Serialiser FSM:
  - IDLE -> HDR when FIFO is non-empty. The head record is loaded into a holding register and popped on entry to HDR.
  - Sequence: HDR -> PC -> INST -> [RWD if reg_we] -> [DWA -> DWD if dmem_we] -> IDLE.
  - Each state advances only on trace_valid & trace_ready.
  - From the final word of a record, the FSM goes directly to HDR if the FIFO is non-empty; there are no bubble cycles.
- Word contents:
  - HDR = {8'hC0, seq[7:0], 7'b0, halt, dmem_we, reg_we, 1'b0, reg_wa[4:0]}
  - PC = pc; INST = inst; RWD = reg_wd; DWA = dmem_wa; DWD = dmem_wd.
- trace_last is 1 on the record's final word: INST, RWD or DWD.
- trace_valid is high in every non-IDLE state.
- While trace_valid=1 and trace_ready=0, trace_data and trace_last hold stable.
- A record needs 3 to 6 words. The FIFO never holds a partially sent record.
- Reset mid-record: the partial record is discarded and the stream restarts cleanly; no partial record is resumed after reset.

Optional Feature:
- Macro COMMIT_TRACE_TS_EN.
- When defined:
  - A 32-bit cycle counter increments on every cycle with global_en=1 (reset 0, wraps).
  - Its value is stored with each pushed record.
  - A TS word is sent between HDR and PC, so records are 4 to 7 words.
  - HDR bit[5]=1.
- When undefined: no counter, no TS word, HDR bit[5]=0.

Test Plan:
- Reset with run=0 -> global_en=0, trace_valid=0, count=0, halted=0, overflow=0.
- run=1, trace_ready=1, one commit pc=0x0000_3000, inst=0x0000_0013, no writes -> 3 words:
  - C000_0000, 0000_3000, 0000_0013; trace_last on the 3rd word.
- Commit with reg_we=1, wa=5, wd=0x1234, dmem_we=1, wa=0x100, wd=0xAB, seq=1 -> 6 words:
  - C001_00C5, pc, inst, 0000_1234, 0000_0100, 0000_00AB; trace_last only on the 6th word.
- trace_ready=0 for 5 cycles mid-record -> trace_data unchanged across those cycles; the next word follows on the first ready cycle.
- DEPTH=16, trace_ready=0, run=1, commit held high -> global_en falls once count=15, count saturates at 16, overflow stays 0.
- Commit with halt=1 -> halted=1 and global_en=0 from the following cycle.
  - The FIFO drains fully and the halt record's HDR has bit[8]=1.
  - Asserting rst=0 mid-drain clears everything and trace_valid falls immediately.
